// File: rtl/sequential_shift_add_multiplier_256bit_pkg.sv
// Shared constants for the 256-bit sequential shift-add multiplier.
// The state encodings match the companion non-restoring divider wherever
// they coincide, so done = state[2] holds for both blocks.
//   STATE_IDLE / STATE_CALC / STATE_DONE : FSM encodings
//   MUL_WIDTH                            : operand width
//   ITER_TERM                            : iteration count at completion
package sequential_shift_add_multiplier_256bit_pkg;

    localparam int unsigned MUL_WIDTH = 256;
    localparam logic [8:0]  ITER_TERM = 9'd256;

    typedef enum logic [2:0] {
        STATE_IDLE = 3'b000,
        STATE_CALC = 3'b001,
        STATE_DONE = 3'b100
    } mul_state_e;

endpackage

// File: rtl/sequential_shift_add_multiplier_256bit_cla.sv
// cla_adder_256: 256-bit carry-lookahead adder with carry out.
// Bits are grouped by four. Each group produces generate/propagate terms,
// and group carries are formed from those terms. Inside a group every bit
// carry is expanded directly from the group carry-in.
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : 256-bit sum
//   cout_o   : carry out of bit 255
module cla_adder_256 (
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    input  logic         cin_i,
    output logic [255:0] sum_o,
    output logic         cout_o
);

    logic [255:0] g;
    logic [255:0] p;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin : lookahead
        logic [64:0]  gc;
        logic [255:0] c;
        gc    = '0;
        c     = '0;
        gc[0] = cin_i;
        for (int k = 0; k < 64; k++) begin
            c[4*k]     = gc[k];
            c[4*k + 1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k + 2] = g[4*k + 1]
                       | (p[4*k + 1] & g[4*k])
                       | (p[4*k + 1] & p[4*k] & gc[k]);
            c[4*k + 3] = g[4*k + 2]
                       | (p[4*k + 2] & g[4*k + 1])
                       | (p[4*k + 2] & p[4*k + 1] & g[4*k])
                       | (p[4*k + 2] & p[4*k + 1] & p[4*k] & gc[k]);
            gc[k + 1]  = g[4*k + 3]
                       | (p[4*k + 3] & g[4*k + 2])
                       | (p[4*k + 3] & p[4*k + 2] & g[4*k + 1])
                       | (p[4*k + 3] & p[4*k + 2] & p[4*k + 1] & g[4*k])
                       | (p[4*k + 3] & p[4*k + 2] & p[4*k + 1] & p[4*k] & gc[k]);
        end
        sum_o  = p ^ c;
        cout_o = gc[64];
    end

endmodule

// File: rtl/sequential_shift_add_multiplier_256bit.sv
// Unsigned 256x256 radix-2 shift-add multiplier with a 512-bit product.
// It performs one add+shift step per clock, so a run takes 256 CALC cycles.
//   clk, reset_n   : clock, async active-low reset
//   start          : load request, honoured only in IDLE or DONE
//   multiplicand_m : multiplicand, captured on the load edge
//   multiplier_q   : multiplier, captured on the load edge
//   product        : {a_reg, q_reg}; the final value is valid while done=1
//   done           : state[2]
//   busy           : high while in CALC
//   state_out      : current FSM encoding
//   count_out      : completed iteration count
//
// Handshake: a load edge is a rising edge on which start=1 and the block
// is in IDLE or DONE. The operands are captured on that edge. While busy
// is high, start and the operand inputs are ignored. Exactly 256 edges
// later done rises, and it stays high until the next load edge or reset.
module sequential_shift_add_multiplier_256bit
    import sequential_shift_add_multiplier_256bit_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] multiplicand_m,
    input  logic [255:0] multiplier_q,
    output logic [511:0] product,
    output logic         done,
    output logic         busy,
    output logic [2:0]   state_out,
    output logic [8:0]   count_out
);

    mul_state_e   state_q, state_d;
    logic [255:0] m_q, m_d;
    logic [255:0] a_q, a_d;
    logic [255:0] q_q, q_d;
    logic [8:0]   count_q, count_d;

    logic [255:0] addend;
    logic [255:0] sum;
    logic         carry;

    // The multiplicand is added only when the multiplier LSB is set.
    assign addend = q_q[0] ? m_q : '0;

    cla_adder_256 u_cla (
        .a_i    (a_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (carry)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        count_d = count_q;
        case (state_q)
            STATE_IDLE, STATE_DONE: begin
                if (start) begin
                    m_d     = multiplicand_m;
                    a_d     = '0;
                    q_d     = multiplier_q;
                    count_d = '0;
                    state_d = STATE_CALC;
                end
            end
            STATE_CALC: begin
                // The carry enters the top bit of a_reg as the 257-bit sum
                // shifts right; dropping it would corrupt large products.
                {a_d, q_d} = {carry, sum, q_q[255:1]};
                count_d    = count_q + 9'd1;
                if (count_q == ITER_TERM - 9'd1) begin
                    state_d = STATE_DONE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    assign product   = {a_q, q_q};
    assign done      = state_q[2];
    assign busy      = (state_q == STATE_CALC);
    assign state_out = state_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_sequential_shift_add_multiplier_256bit.sv
module tb_sequential_shift_add_multiplier_256bit;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [255:0] multiplicand_m;
    logic [255:0] multiplier_q;
    logic [511:0] product;
    logic         done;
    logic         busy;
    logic [2:0]   state_out;
    logic [8:0]   count_out;

    logic [511:0] exp_q[$];
    int           errors;
    int           checks;

    localparam logic [255:0] ALL1 = {256{1'b1}};

    sequential_shift_add_multiplier_256bit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .multiplicand_m (multiplicand_m),
        .multiplier_q   (multiplier_q),
        .product        (product),
        .done           (done),
        .busy           (busy),
        .state_out      (state_out),
        .count_out      (count_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    // Drives a load edge and pushes the expected product. Returns #1 after L.
    task automatic load_op(input logic [255:0] m, input logic [255:0] q,
                           input logic [511:0] expv, input logic hold_start);
        multiplicand_m = m;
        multiplier_q   = q;
        start          = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
    endtask

    // Waits (bounded) for done; returns the number of edges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        multiplicand_m = '0;
        multiplier_q = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (product !== 512'd0 || done !== 1'b0 || busy !== 1'b0 ||
            state_out !== 3'b000 || count_out !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: product=%0h done=%b busy=%b state=%b count=%0d expected all zero",
                     product, done, busy, state_out, count_out);
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [511:0] e;
        load_op(256'd3, 256'd5, 512'd15, 1'b0);
        checks++;
        if (busy !== 1'b1 || state_out !== 3'b001) begin
            errors++;
            $display("FAIL basic_busy: busy=%b state=%b expected 1/001", busy, state_out);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges expected 256", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if (product !== e || count_out !== 9'd256 || state_out !== 3'b100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: product=%0d count=%0d state=%b busy=%b expected %0d/256/100/0",
                     product, count_out, state_out, busy, e);
        end
    endtask

    task automatic test_max();
        int cyc;
        logic [511:0] e;
        load_op(ALL1, ALL1, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 256 || product !== e) begin
            errors++;
            $display("FAIL max_product: cyc=%0d product=%0h expected 256/%0h", cyc, product, e);
        end
    endtask

    task automatic test_zero_one();
        int cyc;
        logic [511:0] e;
        load_op('0, ALL1, 512'd0, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 256 || product !== e) begin
            errors++;
            $display("FAIL zero_times_max: cyc=%0d product=%0h expected 256/%0h", cyc, product, e);
        end
        load_op(ALL1, 256'd1, {256'd0, ALL1}, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 256 || product !== e) begin
            errors++;
            $display("FAIL max_times_one: cyc=%0d product=%0h expected 256/%0h", cyc, product, e);
        end
    endtask

    task automatic test_random();
        int cyc;
        logic [255:0] m, q;
        logic [511:0] e;
        for (int i = 0; i < 3; i++) begin
            m = rand256();
            q = rand256();
            load_op(m, q, {256'd0, m} * {256'd0, q}, 1'b0);
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != 256 || product !== e) begin
                errors++;
                $display("FAIL random_%0d: cyc=%0d product=%0h expected 256/%0h", i, cyc, product, e);
            end
        end
    endtask

    task automatic test_operand_change();
        int cyc;
        logic [255:0] m, q;
        logic [511:0] e;
        m = rand256();
        q = rand256();
        load_op(m, q, {256'd0, m} * {256'd0, q}, 1'b1);
        // Keep start high and scramble operands for most of CALC.
        for (int i = 0; i < 200; i++) begin
            multiplicand_m = rand256();
            multiplier_q   = rand256();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 56 || product !== e) begin
            errors++;
            $display("FAIL operand_change: remaining=%0d product=%0h expected 56/%0h", cyc, product, e);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [511:0] e;
        // Still in DONE from the previous scenario.
        load_op(256'd7, 256'd6, 512'd42, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || count_out !== 9'd0) begin
            errors++;
            $display("FAIL b2b_restart: done=%b busy=%b count=%0d expected 0/1/0", done, busy, count_out);
        end
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 256 || product !== e) begin
            errors++;
            $display("FAIL b2b_product: cyc=%0d product=%0d expected 256/%0d", cyc, product, e);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        multiplicand_m = rand256();
        multiplier_q   = rand256();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (count_out != 9'd100 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (count_out !== 9'd100) begin
            errors++;
            $display("FAIL reach_count_100: count=%0d expected 100", count_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (state_out !== 3'b000 || product !== 512'd0 || done !== 1'b0 ||
            count_out !== 9'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state=%b product=%0h done=%b count=%0d busy=%b expected zeros",
                     state_out, product, done, count_out, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (state_out !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || count_out !== 9'd0) begin
            errors++;
            $display("FAIL idle_after_reset: state=%b busy=%b done=%b count=%0d expected 000/0/0/0",
                     state_out, busy, done, count_out);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero_one();
        test_random();
        test_operand_change();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
